// File: rtl/cfu_pipelined_unit.sv
// Pipelined custom-function unit: fixed-latency ALU/CSR pipeline feeding an in-order
// response queue, with credit-based flow control so responses are never dropped.
module cfu_pipelined_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned NUM_CSRS   = 4,
    parameter logic [11:0] CSR_BASE   = 12'h800
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [31:0]           req_insn,
    input  logic                  req_cfu_csr,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [1:0]            resp_status
);

    localparam int unsigned SHW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CIW  = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusIllegal = 2'd1;
    localparam logic [1:0] StatusBadCsr  = 2'd2;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            status;
    } resp_t;

    logic                  accept;
    logic                  resp_fire;
    logic [2:0]            funct3;
    logic [11:0]           csr_addr;
    logic [4:0]            zimm;
    logic [12:0]           csr_off;
    logic                  csr_hit;
    logic [CIW-1:0]        csr_idx;
    logic [DATA_WIDTH-1:0] csr_old;
    logic [DATA_WIDTH-1:0] csr_src;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic                  csr_we;
    logic [DATA_WIDTH-1:0] csr_q [NUM_CSRS];
    logic                  slt_lt;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [1:0]            acc_status;
    resp_t                 acc_e;
    logic                  push_valid;
    resp_t                 push_e;
    logic [CNTW-1:0]       cnt_q;
    logic [CNTW-1:0]       qcnt_q;
    logic [PTRW-1:0]       wr_ptr_q;
    logic [PTRW-1:0]       rd_ptr_q;
    resp_t                 mem [DEPTH];
    resp_t                 head;
    logic                  unused_insn;

    assign funct3      = req_insn[14:12];
    assign csr_addr    = req_insn[31:20];
    assign zimm        = req_insn[19:15];
    assign unused_insn = ^req_insn[11:0];

    // Depends only on the registered credit count, never on resp_ready.
    assign req_ready = !rst && (cnt_q < CNTW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;

    // A borrow makes the offset huge, so one compare covers both ends of the window.
    assign csr_off = {1'b0, csr_addr} - {1'b0, CSR_BASE};
    assign csr_hit = csr_off < 13'(NUM_CSRS);
    assign csr_idx = csr_off[CIW-1:0];
    assign csr_old = csr_q[csr_idx];
    assign csr_src = funct3[2] ? DATA_WIDTH'(zimm) : req_data0;
    assign slt_lt  = $signed(req_data0) < $signed(req_data1);

    always_comb begin
        acc_data   = '0;
        acc_status = StatusOk;
        csr_we     = 1'b0;
        csr_wdata  = csr_old;
        if (req_cfu_csr) begin
            if (!csr_hit) begin
                acc_status = StatusBadCsr;
            end else if (funct3[1:0] == 2'b00) begin
                acc_status = StatusIllegal;
            end else begin
                acc_data = csr_old;
                csr_we   = accept;
                case (funct3[1:0])
                    2'b01:   csr_wdata = csr_src;
                    2'b10:   csr_wdata = csr_old | csr_src;
                    2'b11:   csr_wdata = csr_old & ~csr_src;
                    default: csr_wdata = csr_old;
                endcase
            end
        end else begin
            unique case (funct3)
                3'd0: acc_data = req_data0 + req_data1;
                3'd1: acc_data = req_data0 - req_data1;
                3'd2: acc_data = req_data0 ^ req_data1;
                3'd3: acc_data = req_data0 & req_data1;
                3'd4: acc_data = req_data0 | req_data1;
                3'd5: acc_data = req_data0 << req_data1[SHW-1:0];
                3'd6: acc_data = {{(DATA_WIDTH-1){1'b0}}, slt_lt};
                3'd7: acc_status = StatusIllegal;
                default: acc_status = StatusIllegal;
            endcase
        end
    end

    assign acc_e = {req_id, acc_data, acc_status};

    // CSR state commits in the accept cycle so the next request sees it immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CSRS); i++) begin
                csr_q[i] <= '0;
            end
        end else if (csr_we) begin
            csr_q[csr_idx] <= csr_wdata;
        end
    end

    // LATENCY-1 register stages; the queue write supplies the final cycle.
    if (LATENCY == 1) begin : g_lat1
        assign push_valid = accept;
        assign push_e     = acc_e;
    end else begin : g_pipe
        logic [LATENCY-2:0] pv_q;
        resp_t              pe_q [LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= accept;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    pv_q[i] <= pv_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pe_q[0] <= acc_e;
            for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                pe_q[i] <= pe_q[i-1];
            end
        end

        assign push_valid = pv_q[LATENCY-2];
        assign push_e     = pe_q[LATENCY-2];
    end

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            qcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_valid) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (resp_fire)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({accept, resp_fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            case ({push_valid, resp_fire})
                2'b10:   qcnt_q <= qcnt_q + 1'b1;
                2'b01:   qcnt_q <= qcnt_q - 1'b1;
                default: qcnt_q <= qcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_valid) mem[wr_ptr_q] <= push_e;
    end

    assign head        = mem[rd_ptr_q];
    assign resp_valid  = (qcnt_q != '0);
    assign resp_id     = resp_valid ? head.id     : '0;
    assign resp_data   = resp_valid ? head.data   : '0;
    assign resp_status = resp_valid ? head.status : '0;

endmodule

// File: tb/tb_cfu_pipelined_unit.sv
// Directed bench for cfu_pipelined_unit: ALU ops, CSR semantics, back-pressure and reset.
module tb_cfu_pipelined_unit;

    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int LAT = 2;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_id = '0;
    logic [31:0]   req_insn = '0;
    logic          req_cfu_csr = 1'b0;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [IW-1:0] resp_id;
    logic [DW-1:0] resp_data;
    logic [1:0]    resp_status;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [IW-1:0] rq_id[$];
    logic [DW-1:0] rq_data[$];
    logic [1:0]    rq_stat[$];
    int            rq_cyc[$];
    int            acc_cyc[$];

    cfu_pipelined_unit #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .LATENCY(LAT), .DEPTH(DEP),
        .NUM_CSRS(4), .CSR_BASE(12'h800)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_insn(req_insn), .req_cfu_csr(req_cfu_csr),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_status(resp_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only at posedge+1, so a negedge sample sees the upcoming handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            rq_id.push_back(resp_id);
            rq_data.push_back(resp_data);
            rq_stat.push_back(resp_status);
            rq_cyc.push_back(cyc);
        end
        if (!rst && req_valid && req_ready) acc_cyc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [11:0] ca,
                                       input logic [4:0] z);
        return {ca, z, f3, 12'h000};
    endfunction

    task automatic clear_logs();
        rq_id.delete(); rq_data.delete(); rq_stat.delete(); rq_cyc.delete(); acc_cyc.delete();
    endtask

    // Holds the request until accepted (bounded); returns at posedge+1 after the handshake.
    task automatic send(input logic [IW-1:0] id, input logic [31:0] insn, input logic csr,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_valid = 1'b1; req_id = id; req_insn = insn; req_cfu_csr = csr;
        req_data0 = d0; req_data1 = d1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resps(input int n, input int budget);
        for (int i = 0; i < budget && rq_id.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
        checks++; if ({resp_id, resp_data, resp_status} !== '0) begin
            errors++; $display("FAIL reset_resp_fields got id %0h data %0h st %0d want 0", resp_id, resp_data, resp_status);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        resp_ready = 1'b1;
        clear_logs();
        send(4'd3, mk(3'd0, 12'h000, 5'd0), 1'b0, 32'd5, 32'd7);
        wait_resps(1, 20);
        checks++; if (rq_id.size() != 1 || acc_cyc.size() != 1) begin
            errors++; $display("FAIL add_count got resp %0d acc %0d want 1 1", rq_id.size(), acc_cyc.size());
        end else begin
            checks++; if (rq_id[0] !== 4'd3 || rq_data[0] !== 32'd12 || rq_stat[0] !== 2'd0) begin
                errors++; $display("FAIL add_value got id %0d data %0d st %0d want 3 12 0", rq_id[0], rq_data[0], rq_stat[0]);
            end
            checks++; if (rq_cyc[0] - acc_cyc[0] != LAT) begin
                errors++; $display("FAIL add_latency got %0d want %0d", rq_cyc[0] - acc_cyc[0], LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]    f3 [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        logic [DW-1:0] a  [8] = '{32'd10, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
        logic [DW-1:0] b  [8] = '{32'd3, 32'h0FF0, 32'h0FF0, 32'h0FF0, 32'd33, 32'd1, 32'd2, 32'd2};
        logic [DW-1:0] ed [8] = '{32'd7, 32'hFF00, 32'h00F0, 32'hFFF0, 32'd6, 32'd1, 32'd0, 32'd1};
        logic [1:0]    es [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        resp_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 8; i++) send(IW'(i), mk(f3[i], 12'h000, 5'd0), 1'b0, a[i], b[i]);
        wait_resps(8, 30);
        checks++; if (acc_cyc.size() != 8 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 7) begin
            errors++; $display("FAIL b2b_throughput got %0d accepts, span %0d want 8 7", acc_cyc.size(),
                               acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] - acc_cyc[0] : -1);
        end
        checks++; if (rq_id.size() != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", rq_id.size()); end
        for (int i = 0; i < 8 && i < rq_id.size(); i++) begin
            checks++; if (rq_id[i] !== IW'(i) || rq_data[i] !== ed[i] || rq_stat[i] !== es[i]) begin
                errors++; $display("FAIL b2b_resp%0d got id %0d data %0h st %0d want %0d %0h %0d",
                                   i, rq_id[i], rq_data[i], rq_stat[i], i, ed[i], es[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        clear_logs();
        req_valid = 1'b1; req_cfu_csr = 1'b0; req_insn = mk(3'd0, 12'h000, 5'd0); req_data1 = 32'd100;
        for (int i = 0; i < 8; i++) begin
            req_id = IW'(acc_cyc.size()); req_data0 = DW'(acc_cyc.size());
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (acc_cyc.size() != DEP) begin errors++; $display("FAIL bp_accepts got %0d want %0d", acc_cyc.size(), DEP); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %0b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_id !== 4'd0 || resp_data !== 32'd100) begin
            errors++; $display("FAIL bp_head_hold got v %0b id %0d data %0d want 1 0 100", resp_valid, resp_id, resp_data);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle got %0b want 0", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %0b want 1", req_ready); end
        wait_resps(DEP, 20);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rq_id.size() != DEP) begin errors++; $display("FAIL bp_drain_count got %0d want %0d", rq_id.size(), DEP); end
        for (int i = 0; i < DEP && i < rq_id.size(); i++) begin
            checks++; if (rq_id[i] !== IW'(i) || rq_data[i] !== DW'(100 + i)) begin
                errors++; $display("FAIL bp_drain%0d got id %0d data %0d want %0d %0d", i, rq_id[i], rq_data[i], i, 100 + i);
            end
        end
    endtask

    task automatic test_csr();
        logic [DW-1:0] ed [4] = '{32'h00, 32'hF0, 32'hFF, 32'hC3};
        resp_ready = 1'b1;
        clear_logs();
        send(4'd0, mk(3'b001, 12'h801, 5'd0), 1'b1, 32'hF0, 32'd0);
        send(4'd1, mk(3'b110, 12'h801, 5'h0F), 1'b1, 32'd0, 32'd0);
        send(4'd2, mk(3'b011, 12'h801, 5'd0), 1'b1, 32'h3C, 32'd0);
        send(4'd3, mk(3'b001, 12'h801, 5'd0), 1'b1, 32'd0, 32'd0);
        wait_resps(4, 20);
        checks++; if (rq_id.size() != 4) begin errors++; $display("FAIL csr_count got %0d want 4", rq_id.size()); end
        for (int i = 0; i < 4 && i < rq_id.size(); i++) begin
            checks++; if (rq_data[i] !== ed[i] || rq_stat[i] !== 2'd0) begin
                errors++; $display("FAIL csr_seq%0d got data %0h st %0d want %0h 0", i, rq_data[i], rq_stat[i], ed[i]);
            end
        end
    endtask

    task automatic test_bad_csr();
        logic [DW-1:0] ed [5] = '{32'h00, 32'h00, 32'h00, 32'h55, 32'h00};
        logic [1:0]    es [5] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
        resp_ready = 1'b1;
        clear_logs();
        send(4'd0, mk(3'b001, 12'h800, 5'd0), 1'b1, 32'h55, 32'd0);
        send(4'd1, mk(3'b001, 12'h7FF, 5'd0), 1'b1, 32'd5, 32'd0);
        send(4'd2, mk(3'b000, 12'h800, 5'd0), 1'b1, 32'hAA, 32'd0);
        send(4'd3, mk(3'b110, 12'h800, 5'd0), 1'b1, 32'd0, 32'd0);
        send(4'd4, mk(3'b001, 12'h804, 5'd0), 1'b1, 32'd9, 32'd0);
        wait_resps(5, 20);
        checks++; if (rq_id.size() != 5) begin errors++; $display("FAIL badcsr_count got %0d want 5", rq_id.size()); end
        for (int i = 0; i < 5 && i < rq_id.size(); i++) begin
            checks++; if (rq_stat[i] !== es[i] || (es[i] != 2'd1 && rq_data[i] !== ed[i])) begin
                errors++; $display("FAIL badcsr%0d got data %0h st %0d want %0h %0d", i, rq_data[i], rq_stat[i], ed[i], es[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        resp_ready = 1'b1;
        clear_logs();
        send(4'd0, mk(3'b001, 12'h802, 5'd0), 1'b1, 32'h1234, 32'd0);
        wait_resps(1, 20);
        resp_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 3; i++) send(IW'(i + 1), mk(3'd0, 12'h000, 5'd0), 1'b0, 32'd1, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready_in_reset got %0b want 0", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mrst_after got resp_valid %0b req_ready %0b want 0 1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        send(4'd9, mk(3'b110, 12'h802, 5'd0), 1'b1, 32'd0, 32'd0);
        wait_resps(1, 20);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (rq_id.size() != 1) begin errors++; $display("FAIL mrst_stale got %0d responses want 1", rq_id.size()); end
        else begin
            checks++; if (rq_id[0] !== 4'd9 || rq_data[0] !== 32'd0 || rq_stat[0] !== 2'd0) begin
                errors++; $display("FAIL mrst_csr_clear got id %0d data %0h st %0d want 9 0 0", rq_id[0], rq_data[0], rq_stat[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_csr();
        test_bad_csr();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_pipelined_unit.md
# cfu_pipelined_unit

Parametrised successor to the single-entry custom-function unit. It accepts one CFU request per cycle, runs it through a fixed-latency pipeline and returns responses in order through a bounded output queue. Flow control is credit-based, so responses are never lost under back-pressure. It adds a selectable ALU operation set, a bank of CSRs with full RW/RS/RC semantics, and defined error statuses. It sits on the core's CFU request/response channel, in place of the single-entry unit.

## Interface
- DATA_WIDTH, 32: operand/result width
- ID_WIDTH, 4: request tag width
- LATENCY, 2: pipeline stages, accept to response (legal range 1..8)
- DEPTH, 4: max in-flight plus queued responses (must be >= 1)
- NUM_CSRS, 4: CSR count; addresses CSR_BASE .. CSR_BASE+NUM_CSRS-1
- CSR_BASE, 12'h800: first CSR address
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept
- req_id  in  ID_WIDTH  request tag
- req_insn  in  32  raw instruction
- req_cfu_csr  in  1  request is a CSR op
- req_data0, req_data1  in  DATA_WIDTH  rs1/rs2 values
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_id  out  ID_WIDTH  echoed tag
- resp_data  out  DATA_WIDTH  result
- resp_status  out  2  0 ok, 1 illegal op, 2 bad CSR address

## Operation
- Accept when req_valid && req_ready. Fields used: funct3 = insn[14:12], csr_addr = insn[31:20], zimm = insn[19:15].
- Non-CSR ops, selected by funct3:
  - 0 add, 1 sub (d0-d1), 2 xor, 3 and, 4 or.
  - 5 sll, by d1[$clog2(DATA_WIDTH)-1:0].
  - 6 signed slt, result 0/1.
  - 7 illegal: data 0, status 1.
- All arithmetic is modulo 2^DATA_WIDTH.
- CSR source is zimm zero-extended when funct3[2]=1, else d0.
- CSR op by funct3[1:0]:
  - 01 RW: new = src.
  - 10 RS: new = old | src.
  - 11 RC: new = old & ~src.
  - 00: illegal, status 1, no write.
- A CSR response returns the old value. CSR read and write commit in the accept cycle, so back-to-back CSR ops see each other's writes.
- CSR address outside the range gives status 2, data 0, no write.
- Credit counter cnt = requests in pipeline + entries in the queue.
  - req_ready = !rst && cnt < DEPTH.
  - cnt +1 on accept, -1 on response handshake; both in the same cycle leaves it unchanged.
- Responses come out in accept order; resp_* reflect the queue head.

## Timing
- Reset values:
  - resp_valid 0, req_ready 0 while rst=1, resp_id/resp_data/resp_status 0.
  - All CSRs 0, cnt 0, pipeline and queue empty.
- Reset mid-operation discards all in-flight requests and queued responses. req_ready is 1 in the first cycle after rst deasserts.
- Latency: a request accepted in cycle N gives resp_valid in cycle N+LATENCY when the queue is empty and drained.
- Response handshake is resp_valid && resp_ready. The head must hold stable while resp_ready=0.
- Pipeline stages always advance. The credit counter guarantees queue space, so the pipeline never stalls.
- Throughput is 1 request/cycle sustained when DEPTH >= LATENCY+1 and resp_ready=1. With a smaller DEPTH, req_ready drops once cnt reaches DEPTH.
- Full boundary: at cnt=DEPTH, a response handshake raises req_ready the following cycle. There is no combinational path from resp_ready to req_ready.
- Empty boundary: resp_valid=0 and resp_ready is ignored.
- Queue pointers wrap modulo DEPTH. Full and empty must be distinguished; the queue holds DEPTH entries.

## Test plan
- Single add, LATENCY=2, resp_ready=1:
  - Stimulus: id 3, funct3 0, d0=5, d1=7, accepted in cycle 10.
  - Required: resp_valid in cycle 12 with id 3, data 12, status 0.
- Back-to-back stream, DEPTH=4, LATENCY=2:
  - Stimulus: 8 requests in consecutive cycles: sub, xor, and, or, sll (d1=33, so shift 1), slt (-1 < 1), funct3 7, add.
  - Required: req_ready stays 1. Responses arrive in order with correct values; the slt response is 1; the funct3 7 response is data 0, status 1.
- Back-pressure:
  - Stimulus: hold resp_ready=0 and issue requests.
  - Required: req_ready falls after exactly DEPTH accepts. Releasing resp_ready drains all DEPTH responses in order with no loss or duplication. req_ready returns one cycle after the first drain handshake.
- CSR sequence on address 0x801:
  - Stimulus: CSRRW d0=0xF0, then CSRRS zimm=0x0F, then CSRRC d0=0x3C, then CSRRW d0=0.
  - Required: returned data 0, 0xF0, 0xFF, 0xC3.
- Bad CSR address:
  - Stimulus: CSR op to 0x7FF, and funct3[1:0]=00 to 0x800.
  - Required: statuses 2 and 1; 0x800 unchanged.
- Mid-stream reset:
  - Stimulus: rst=1 for one cycle with 3 requests in flight.
  - Required: resp_valid 0 the next cycle, CSRs 0, req_ready 1; no stale response appears afterward.
